cla_seq_subtractor: RTL and testbench

- Multi-cycle two's-complement subtractor computing DIFF = A − B − borrow_in.
- Processes one 4-bit carry-lookahead slice per clock. The slice uses inverted-B propagate/generate, and the slice carry is held in a register between cycles.
- Complements the team's 4-bit CLA adder slice: it consumes the same p/g lookahead structure in the subtract direction. It serves as the ALU's narrow-area subtract/compare path.
- Operands enter and results leave through valid/ready handshakes.

---
 rtl/cla_seq_subtractor.sv | 142 ++++++++++++++
 tb/tb_cla_seq_subtractor.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/cla_seq_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : cla_seq_subtractor
// Brief    : Multi-cycle A - B - borrow_in, one 4-bit lookahead slice per clock
// Revision : 1.0  initial release
// ============================================================================
module cla_seq_subtractor #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow,
  output logic             zero
);

  localparam int NSLICE = WIDTH / 4;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             borrow_q, borrow_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic [3:0]       a_sl, b_sl, p, g, sum;
  logic [4:0]       c;
  logic [WIDTH-1:0] acc_nxt;
  logic             last;

  always_comb begin
    a_sl = a_q[{cnt_q, 2'b00} +: 4];
    b_sl = b_q[{cnt_q, 2'b00} +: 4];
    p    = a_sl ^ ~b_sl;
    g    = a_sl & ~b_sl;
    c[0] = carry_q;
    c[1] = g[0] | (p[0] & c[0]);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c[0]);
    sum  = p ^ c[3:0];
    // Partial result builds in acc so the visible diff only changes at completion
    acc_nxt = acc_q;
    acc_nxt[{cnt_q, 2'b00} +: 4] = sum;
    last = (cnt_q == CW'(NSLICE - 1));
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    diff_d   = diff_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    borrow_d = borrow_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = ~borrow_in;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d   = acc_nxt;
        carry_d = c[4];
        cnt_d   = cnt_q + CW'(1);
        if (last) begin
          diff_d   = acc_nxt;
          borrow_d = ~c[4];
          ovf_d    = c[4] ^ c[3];
          zero_d   = (acc_nxt == '0);
          state_d  = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      diff_q   <= diff_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      borrow_q <= borrow_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign diff       = diff_q;
  assign borrow_out = borrow_q;
  assign overflow   = ovf_q;
  assign zero       = zero_q;

endmodule
`default_nettype wire

// File: tb/tb_cla_seq_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : tb_cla_seq_subtractor
// Brief    : Directed vector bench for cla_seq_subtractor (WIDTH=16)
// Revision : 1.0  initial release
// ============================================================================
module tb_cla_seq_subtractor;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a, b;
  logic        borrow_in;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] diff;
  logic        borrow_out;
  logic        overflow;
  logic        zero;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic [15:0] d;
    logic        bo;
    logic        ov;
    logic        z;
  } vec_t;

  vec_t vecs [11];

  cla_seq_subtractor #(.WIDTH(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .borrow_in (borrow_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .borrow_out(borrow_out),
    .overflow  (overflow),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Accepts one op and returns the number of cycles until out_valid (0 on timeout)
  task automatic start_and_wait(input vec_t v, input logic ordy, output int lat);
    @(negedge clk);
    chk("in_ready_before_accept", {31'b0, in_ready}, 32'd1);
    a = v.a; b = v.b; borrow_in = v.bin; in_valid = 1'b1; out_ready = ordy;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("in_ready_after_accept", {31'b0, in_ready}, 32'd0);
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic check_result(input vec_t v, input string tag);
    chk({tag, "_diff"},   {16'b0, diff},       {16'b0, v.d});
    chk({tag, "_borrow"}, {31'b0, borrow_out}, {31'b0, v.bo});
    chk({tag, "_ovf"},    {31'b0, overflow},   {31'b0, v.ov});
    chk({tag, "_zero"},   {31'b0, zero},       {31'b0, v.z});
  endtask

  task automatic run_op(input vec_t v, input string tag);
    int lat;
    start_and_wait(v, 1'b1, lat);
    chk({tag, "_latency"}, lat, 32'd4);
    check_result(v, tag);
    @(posedge clk);
    #1;
    chk({tag, "_out_valid_drop"}, {31'b0, out_valid}, 32'd0);
    chk({tag, "_in_ready_back"},  {31'b0, in_ready},  32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t bp, rs;
    int   lat;
    vecs[0]  = '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0};
    vecs[4]  = '{16'h5555, 16'h5555, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{16'h5555, 16'h5555, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{16'h00FF, 16'h0001, 1'b0, 16'h00FE, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{16'hFFFF, 16'h0000, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{16'h8000, 16'h0000, 1'b1, 16'h7FFF, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{16'h1234, 16'h1234, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1};

    reset = 1'b1; in_valid = 1'b0; a = '0; b = '0; borrow_in = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready",  {31'b0, in_ready},   32'd1);
    chk("rst_out_valid", {31'b0, out_valid},  32'd0);
    chk("rst_diff",      {16'b0, diff},       32'd0);
    chk("rst_flags",     {29'b0, borrow_out, overflow, zero}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 11; i++) run_op(vecs[i], $sformatf("vec%0d", i));

    // Backpressure: result must hold while out_ready stays low and inputs churn
    bp = vecs[0];
    start_and_wait(bp, 1'b0, lat);
    chk("bp_latency", lat, 32'd4);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      a = 16'($urandom); b = 16'($urandom); borrow_in = ~borrow_in; in_valid = ~in_valid;
      @(posedge clk);
      #1;
      chk($sformatf("bp_hold%0d_valid", k), {31'b0, out_valid}, 32'd1);
      chk($sformatf("bp_hold%0d_ready", k), {31'b0, in_ready},  32'd0);
      check_result(bp, $sformatf("bp_hold%0d", k));
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_ready", {31'b0, in_ready},  32'd1);
    chk("bp_release_valid", {31'b0, out_valid}, 32'd0);
    run_op(vecs[1], "bp_next");

    // Reset during the second RUN cycle discards the op and clears outputs
    rs = vecs[6];
    @(negedge clk);
    a = rs.a; b = rs.b; borrow_in = rs.bin; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_in_ready",  {31'b0, in_ready},  32'd1);
    chk("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("mid_rst_diff",      {16'b0, diff},      32'd0);
    chk("mid_rst_flags",     {29'b0, borrow_out, overflow, zero}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    run_op(rs, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
